// File: rtl/pc_sequencer.sv
// KGP_RISC program-counter sequencer: owns the PC, runs the IDLE/FETCH/EXEC/HALTED loop.
// Optional range checking of fetch addresses is compiled in with `define PC_BOUNDS_CHECK_EN.
module pc_sequencer #(
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int unsigned       IMEM_BYTES   = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  output logic              instr_valid,
  input  logic              exec_done,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              halt_instr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] npc,
  output logic              busy,
  output logic              halted,
  output logic              fault
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALTED
  } state_t;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc_nx;
  logic              valid_nx;
  logic              enter_fetch;
  logic              fetch_blocked;

  // Branch targets are word-aligned by clearing the two low address bits.
  assign npc = pc + ADDR_W'(4);

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    valid_nx    = 1'b0;
    enter_fetch = 1'b0;
    case (state)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_nx    = S_FETCH;
          pc_nx       = RESET_VECTOR;
          enter_fetch = 1'b1;
        end
      end
      S_FETCH: begin
        if (fetch_blocked) begin
          state_nx = S_HALTED;
        end else if (imem_ack) begin
          state_nx = S_EXEC;
          valid_nx = 1'b1;
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          if (halt_instr) begin
            state_nx = S_HALTED;
          end else begin
            state_nx    = S_FETCH;
            enter_fetch = 1'b1;
            pc_nx       = br_taken ? (br_target & ALIGN_MASK) : npc;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments and a synchronous reset sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= RESET_VECTOR;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      instr_valid <= valid_nx;
    end
  end

`ifdef PC_BOUNDS_CHECK_EN
  localparam logic [ADDR_W-1:0] IMEM_LIMIT = ADDR_W'(IMEM_BYTES);

  logic fault_q;

  // Evaluated on every FETCH entry, so an in-range restart clears a sticky fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (enter_fetch) begin
      fault_q <= (pc_nx >= IMEM_LIMIT);
    end
  end

  assign fault         = fault_q;
  assign fetch_blocked = fault_q;
`else
  assign fault         = 1'b0;
  assign fetch_blocked = 1'b0;
`endif

  assign imem_req  = (state == S_FETCH) && !fetch_blocked;
  assign imem_addr = imem_req ? pc : '0;
  assign busy      = (state == S_FETCH) || (state == S_EXEC);
  assign halted    = (state == S_HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, corner sequences,
// and randomized traffic compared against an instruction-level reference model.
module tb_pc_sequencer;

  logic        clk;
  logic        rst, start, imem_ack, exec_done, br_taken, halt_instr;
  logic [31:0] br_target;
  logic        imem_req, instr_valid, busy, halted, fault;
  logic [31:0] imem_addr, pc, npc;

  int checks = 0;
  int errors = 0;

`ifdef PC_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif
  localparam logic [31:0] RV = 32'h0;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .instr_valid(instr_valid), .exec_done(exec_done), .br_taken(br_taken),
    .br_target(br_target), .halt_instr(halt_instr), .pc(pc), .npc(npc),
    .busy(busy), .halted(halted), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: which phase the processor is in and where it is.
  bit          m_fetching, m_executing, m_stopped, m_pulse, m_fault;
  logic [31:0] m_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_begin_fetch(input logic [31:0] addr);
    m_pc       = addr;
    m_fetching = 1'b1;
    m_fault    = BOUNDS && (addr >= 32'd4096);
  endtask

  task automatic model_step();
    bit pulse_next;
    pulse_next = 1'b0;
    if (rst) begin
      m_fetching = 0; m_executing = 0; m_stopped = 0; m_fault = 0;
      m_pc = RV;
    end else if (m_fetching) begin
      if (m_fault) begin
        m_fetching = 0; m_stopped = 1;
      end else if (imem_ack) begin
        m_fetching = 0; m_executing = 1; pulse_next = 1'b1;
      end
    end else if (m_executing) begin
      if (exec_done) begin
        m_executing = 0;
        if (halt_instr) m_stopped = 1;
        else if (br_taken) model_begin_fetch({br_target[31:2], 2'b00});
        else model_begin_fetch(m_pc + 32'd4);
      end
    end else if (start) begin
      m_stopped = 0;
      model_begin_fetch(RV);
    end
    m_pulse = pulse_next;
  endtask

  task automatic check_model();
    logic req_e;
    req_e = m_fetching && !m_fault;
    check("imem_req",    imem_req,    req_e);
    check("imem_addr",   imem_addr,   req_e ? m_pc : 32'h0);
    check("instr_valid", instr_valid, m_pulse);
    check("pc",          pc,          m_pc);
    check("npc",         npc,         m_pc + 32'd4);
    check("busy",        busy,        m_fetching || m_executing);
    check("halted",      halted,      m_stopped);
    check("fault",       fault,       m_fault);
  endtask

  // Apply inputs, advance the model and the DUT by one edge, land 1ns after it.
  task automatic tick(input logic r, s, a, d, b, h, input logic [31:0] t);
    rst = r; start = s; imem_ack = a; exec_done = d; br_taken = b; halt_instr = h;
    br_target = t;
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst, start, ack, done, br, halt;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        valid, busy, halted;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, s, a, d, b, h, input logic [31:0] t,
                              input logic req, input logic [31:0] addr,
                              input logic v, bz, hl, input logic [31:0] p);
    vec_t x;
    x.rst = r; x.start = s; x.ack = a; x.done = d; x.br = b; x.halt = h; x.tgt = t;
    x.req = req; x.addr = addr; x.valid = v; x.busy = bz; x.halted = hl; x.pc = p;
    return x;
  endfunction

  initial begin
    rst = 0; start = 0; imem_ack = 0; exec_done = 0; br_taken = 0; halt_instr = 0;
    br_target = 32'h0;
    m_fetching = 0; m_executing = 0; m_stopped = 0; m_pulse = 0; m_fault = 0; m_pc = RV;

    //              rst s a d b h  tgt          req addr          v bz hl pc
    tbl.push_back(mk(1, 0,0,0,0,0, 32'h0,        0, 32'h0,        0,0,0, 32'h0));
    tbl.push_back(mk(0, 1,0,0,0,0, 32'h0,        1, 32'h0,        0,1,0, 32'h0));
    tbl.push_back(mk(0, 0,0,0,0,0, 32'h0,        1, 32'h0,        0,1,0, 32'h0));
    tbl.push_back(mk(0, 0,1,0,0,0, 32'h0,        0, 32'h0,        1,1,0, 32'h0));
    tbl.push_back(mk(0, 0,0,1,0,0, 32'h0,        1, 32'h4,        0,1,0, 32'h4));
    tbl.push_back(mk(0, 0,0,0,0,0, 32'h0,        1, 32'h4,        0,1,0, 32'h4));
    tbl.push_back(mk(0, 0,1,0,0,0, 32'h0,        0, 32'h0,        1,1,0, 32'h4));
    tbl.push_back(mk(0, 0,0,1,0,0, 32'h0,        1, 32'h8,        0,1,0, 32'h8));
    tbl.push_back(mk(0, 0,0,0,0,0, 32'h0,        1, 32'h8,        0,1,0, 32'h8));
    tbl.push_back(mk(0, 0,1,0,0,0, 32'h0,        0, 32'h0,        1,1,0, 32'h8));
    tbl.push_back(mk(0, 0,0,1,0,0, 32'h0,        1, 32'hC,        0,1,0, 32'hC));
    tbl.push_back(mk(0, 0,1,0,0,0, 32'h0,        0, 32'h0,        1,1,0, 32'hC));
    tbl.push_back(mk(0, 0,0,1,0,0, 32'h0,        1, 32'h10,       0,1,0, 32'h10));
    tbl.push_back(mk(0, 1,1,0,0,0, 32'h0,        0, 32'h0,        1,1,0, 32'h10));
    tbl.push_back(mk(0, 0,0,1,1,0, 32'h47,       1, 32'h44,       0,1,0, 32'h44));
    tbl.push_back(mk(0, 0,1,0,0,0, 32'h0,        0, 32'h0,        1,1,0, 32'h44));
    tbl.push_back(mk(0, 0,0,1,1,0, 32'h20,       1, 32'h20,       0,1,0, 32'h20));
    tbl.push_back(mk(0, 0,1,0,0,0, 32'h0,        0, 32'h0,        1,1,0, 32'h20));
    tbl.push_back(mk(0, 0,0,1,1,1, 32'h47,       0, 32'h0,        0,0,1, 32'h20));
    tbl.push_back(mk(0, 0,1,1,1,1, 32'h80,       0, 32'h0,        0,0,1, 32'h20));
    tbl.push_back(mk(0, 1,0,0,0,0, 32'h0,        1, 32'h0,        0,1,0, 32'h0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 1,0,1,1,0, 32'h40,     1, 32'h0,        0,1,0, 32'h0));
    tbl.push_back(mk(1, 0,0,0,0,0, 32'h0,        0, 32'h0,        0,0,0, 32'h0));
    tbl.push_back(mk(0, 0,1,1,0,0, 32'h0,        0, 32'h0,        0,0,0, 32'h0));

    foreach (tbl[i]) begin
      tick(tbl[i].rst, tbl[i].start, tbl[i].ack, tbl[i].done, tbl[i].br, tbl[i].halt, tbl[i].tgt);
      check($sformatf("vec%0d.imem_req", i),    imem_req,    tbl[i].req);
      check($sformatf("vec%0d.imem_addr", i),   imem_addr,   tbl[i].addr);
      check($sformatf("vec%0d.instr_valid", i), instr_valid, tbl[i].valid);
      check($sformatf("vec%0d.busy", i),        busy,        tbl[i].busy);
      check($sformatf("vec%0d.halted", i),      halted,      tbl[i].halted);
      check($sformatf("vec%0d.pc", i),          pc,          tbl[i].pc);
      check($sformatf("vec%0d.npc", i),         npc,         tbl[i].pc + 32'd4);
      check($sformatf("vec%0d.fault", i),       fault,       1'b0);
    end

`ifndef PC_BOUNDS_CHECK_EN
    // Top-of-memory wrap: 0xFFFF_FFFC + 4 fetches from 0.
    tick(1,0,0,0,0,0, 32'h0);
    tick(0,1,0,0,0,0, 32'h0);
    tick(0,0,1,0,0,0, 32'h0);
    tick(0,0,0,1,1,0, 32'hFFFF_FFFF);
    check("wrap.addr_top", imem_addr, 32'hFFFF_FFFC);
    check("wrap.npc_top",  npc,       32'h0);
    tick(0,0,1,0,0,0, 32'h0);
    tick(0,0,0,1,0,0, 32'h0);
    check("wrap.addr_zero", imem_addr, 32'h0);
    check("wrap.req",       imem_req,  1'b1);
`else
    // Branch past the end of instruction memory faults without issuing a fetch.
    tick(1,0,0,0,0,0, 32'h0);
    tick(0,1,0,0,0,0, 32'h0);
    tick(0,0,1,0,0,0, 32'h0);
    tick(0,0,0,1,1,0, 32'h0000_1000);
    check("oob.fault_entry", fault,    1'b1);
    check("oob.no_req",      imem_req, 1'b0);
    tick(0,0,1,0,0,0, 32'h0);
    check("oob.halted",      halted,   1'b1);
    check("oob.fault_held",  fault,    1'b1);
    check("oob.req_halted",  imem_req, 1'b0);
    tick(0,1,0,0,0,0, 32'h0);
    check("oob.fault_clear", fault,    1'b0);
    check("oob.refetch",     imem_req, 1'b1);
    check("oob.addr",        imem_addr, 32'h0);
`endif
    check_model();

    // Reset during EXEC together with a redirect: the redirect is discarded.
    tick(0,1,0,0,0,0, 32'h0);
    tick(0,0,1,0,0,0, 32'h0);
    tick(1,0,0,1,1,0, 32'h0000_0200);
    check("rst_exec.pc",   pc,   RV);
    check("rst_exec.busy", busy, 1'b0);
    check_model();

    // Randomized traffic checked cycle by cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] t;
      t = ($urandom_range(0, 3) == 0) ? $urandom() : {20'h0, 12'($urandom())};
      tick(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 1) == 0),
           ($urandom_range(0, 7) == 0),
           t);
      check_model();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
